// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the IF-stage fetch controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 65;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_bus(input logic adef,
                                                          input logic [31:0] pc,
                                                          input logic [31:0] inst);
    return {adef, pc, inst};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction port: the fetch controller is master, the memory is slave.
interface if_fetch_ctrl_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC, keeps at most one SRAM read outstanding and
// drops fetches made stale by WB/ID redirects. Optional macro IF_ADEF_CHECK_EN: misaligned-PC fault.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       expt_clear,
  input  logic [31:0]                expt_refresh_pc,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  if_fetch_ctrl_if.master            inst_sram
);

  fetch_state_t               state, state_n;
  logic [31:0]                pc, pc_n, pend_pc, pend_pc_n, target;
  logic                       pend_v, pend_v_n, pend_ex, pend_ex_n, discard, discard_n;
  logic [FS_TO_DS_BUS_WD-1:0] bus_q, bus_n;
  logic                       redirect, take_pend, req, adef;

  assign redirect = expt_clear | br_taken;
  assign target   = expt_clear ? expt_refresh_pc : br_target;
  // A branch never displaces an exception redirect that is still pending.
  assign take_pend = expt_clear | (br_taken & ~(pend_v & pend_ex));

`ifdef IF_ADEF_CHECK_EN
  assign adef = (pc[1:0] != 2'b00);
`else
  assign adef = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      pend_pc <= '0;
      pend_v  <= 1'b0;
      pend_ex <= 1'b0;
      discard <= 1'b0;
      bus_q   <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_pc_n;
      pend_v  <= pend_v_n;
      pend_ex <= pend_ex_n;
      discard <= discard_n;
      bus_q   <= bus_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    pend_v_n  = pend_v;
    pend_ex_n = pend_ex;
    discard_n = discard;
    bus_n     = bus_q;
    req       = 1'b0;
    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (redirect) pc_n = target;
      end
      S_REQ: begin
        if (adef) begin
          if (redirect) pc_n = target;
          else begin
            bus_n   = pack_bus(1'b1, pc, '0);
            state_n = S_HOLD;
          end
        end else begin
          req = 1'b1;
          if (take_pend) begin
            pend_v_n  = 1'b1;
            pend_pc_n = target;
            pend_ex_n = expt_clear;
          end
          if (inst_sram.addr_ok) begin
            state_n   = S_WAIT;
            discard_n = pend_v | redirect;
          end
        end
      end
      S_WAIT: begin
        if (inst_sram.data_ok) begin
          state_n   = S_REQ;
          pend_v_n  = 1'b0;
          discard_n = 1'b0;
          // Stale return: restart at the surviving redirect, folding in one arriving now.
          if (discard || redirect) pc_n = take_pend ? target : pend_pc;
          else begin
            bus_n   = pack_bus(1'b0, pc, inst_sram.rdata);
            state_n = S_HOLD;
          end
        end else if (redirect) begin
          discard_n = 1'b1;
          if (take_pend) begin
            pend_v_n  = 1'b1;
            pend_pc_n = target;
            pend_ex_n = expt_clear;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n    = target;
          state_n = S_REQ;
        end else if (ds_allowin) begin
          pc_n    = pc + 32'd4;
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign fs_to_ds_valid  = (state == S_HOLD);
  assign fs_to_ds_bus    = bus_q;
  assign inst_sram.req   = req;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'b10;
  assign inst_sram.wstrb = '0;
  assign inst_sram.addr  = pc;
  assign inst_sram.wdata = '0;

endmodule
